// File: rtl/cpc_backplane_arbiter_pkg.sv
// Shared types for the CPC backplane arbiter: FSM state encoding and the
// helper that sizes the GRANT_ID field from the slot count.
package cpc_backplane_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // A slot index always needs at least one bit, even for two slots.
  function automatic int gid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpc_backplane_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of req, starting
// at (ptr+1) mod N and wrapping upward.
module rr_pick
  import cpc_backplane_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = gid_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int         cand_i;
  logic [W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    cand_i = 0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand_i = (int'(ptr) + k) % N;
      cand   = W'(cand_i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cpc_backplane_arbiter.sv
// Expansion-slot bus arbiter for the CPC backplane: merges ROM/RAM disables,
// stretches the backplane reset and hands the CPU bus to one slot at a time.
module cpc_backplane_arbiter
  import cpc_backplane_arbiter_pkg::*;
#(
  parameter int NSLOTS      = 4,
  parameter int RST_STRETCH = 16,
  localparam int GW         = gid_width(NSLOTS)
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic [NSLOTS-1:0] SLOT_EN,
  input  logic [NSLOTS-1:0] SLOT_BUSRQ_B,
  output logic [NSLOTS-1:0] SLOT_BUSACK_B,
  output logic              BUSRQ_B,
  input  logic              BUSACK_B,
  input  logic [NSLOTS-1:0] SLOT_ROMDIS,
  input  logic [NSLOTS-1:0] SLOT_RAMDIS,
  output logic              ROMDIS,
  output logic              RAMDIS,
  output logic [GW-1:0]     GRANT_ID,
  output logic              BUSY,
  output logic              BUSRESET_B,
  output logic [1:0]        DBG_STATE
);

  // Handshake: a slot holds SLOT_BUSRQ_B low for as long as it wants the bus;
  // it owns the bus only while its SLOT_BUSACK_B bit is low, and must keep
  // requesting until then. Dropping the request (or its enable) ends the
  // tenure and BUSRQ_B is returned to the CPU before anyone else is served.

  assign ROMDIS = |(SLOT_ROMDIS & SLOT_EN);
  assign RAMDIS = |(SLOT_RAMDIS & SLOT_EN);

  logic [7:0] cnt_q, cnt_d;
  logic       busreset_b_q, busreset_b_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    busreset_b_d = (cnt_d == 8'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      cnt_q        <= 8'(RST_STRETCH);
      busreset_b_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      busreset_b_q <= busreset_b_d;
    end
  end

  assign BUSRESET_B = busreset_b_q;

  logic [NSLOTS-1:0] req_valid;
  logic              pick_valid;
  logic [GW-1:0]     pick_idx;

  assign req_valid = ~SLOT_BUSRQ_B & SLOT_EN;

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic              busrq_b_q, busrq_b_d;
  logic [NSLOTS-1:0] slot_busack_b_q, slot_busack_b_d;

  rr_pick #(.N(NSLOTS), .W(GW)) u_rr_pick (
    .req   (req_valid),
    .ptr   (last_grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_q         <= ST_IDLE;
      grant_id_q      <= '0;
      last_grant_q    <= GW'(NSLOTS - 1);
      busrq_b_q       <= 1'b1;
      slot_busack_b_q <= '1;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      busrq_b_q       <= busrq_b_d;
      slot_busack_b_q <= slot_busack_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (busreset_b_q && pick_valid) begin
          state_d    = ST_REQ;
          grant_id_d = pick_idx;
        end
      end
      ST_REQ: begin
        // A withdrawal wins over a same-cycle ack: never grant a slot that left.
        if (!req_valid[grant_id_q]) begin
          state_d = ST_RELEASE;
        end else if (!BUSACK_B) begin
          state_d      = ST_GRANT;
          last_grant_d = grant_id_q;
        end
      end
      ST_GRANT: begin
        if (!req_valid[grant_id_q]) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (BUSACK_B) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // BUSRQ_B asserts one cycle into REQ and is held through GRANT.
  always_comb begin
    busrq_b_d = 1'b1;
    if ((state_d == ST_GRANT) || (state_q == ST_REQ && state_d == ST_REQ))
      busrq_b_d = 1'b0;
    slot_busack_b_d = '1;
    if (state_d == ST_GRANT) slot_busack_b_d[grant_id_d] = 1'b0;
  end

  assign BUSRQ_B       = busrq_b_q;
  assign SLOT_BUSACK_B = slot_busack_b_q;
  assign GRANT_ID      = grant_id_q;
  assign BUSY          = (state_q != ST_IDLE);
  assign DBG_STATE     = state_q;

endmodule

// File: doc/cpc_backplane_arbiter.md
CPC_BACKPLANE_ARBITER -- requirements
Module: cpc_backplane_arbiter

Interface
REQ-001 The block SHALL have parameter NSLOTS, default 4, meaning the number of expansion slots (legal range 2..8).
REQ-002 The block SHALL have parameter RST_STRETCH, default 16, meaning the number of CLK cycles BUSRESET_B is held low after reset release (range 1..255).
REQ-003 The block SHALL have one clock and one reset, listed first: CLK  in  1  CPU clock; RESET_B  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have SLOT_EN  in  NSLOTS  static per-slot enable mask, 1 = slot populated and enabled.
REQ-005 The block SHALL have SLOT_BUSRQ_B  in  NSLOTS  per-slot bus request, active low.
REQ-006 The block SHALL have SLOT_BUSACK_B  out  NSLOTS  per-slot bus acknowledge, active low.
REQ-007 The block SHALL have BUSRQ_B  out  1  bus request to the CPU, and BUSACK_B  in  1  bus acknowledge from the CPU, both active low.
REQ-008 The block SHALL have SLOT_ROMDIS  in  NSLOTS and SLOT_RAMDIS  in  NSLOTS  per-slot disables, plus ROMDIS  out  1 and RAMDIS  out  1  merged disables.
REQ-009 The block SHALL have GRANT_ID  out  max(1,ceil(log2 NSLOTS))  index of the current or last granted slot, and BUSY  out  1  high whenever the FSM is not IDLE.
REQ-010 The block SHALL have BUSRESET_B  out  1  stretched backplane reset, active low.

Function
REQ-011 ROMDIS SHALL be combinational: the OR of SLOT_ROMDIS[i] AND SLOT_EN[i] over all i. RAMDIS SHALL be formed the same way from SLOT_RAMDIS.
REQ-012 A request is valid SHALL mean SLOT_BUSRQ_B[i]=0 AND SLOT_EN[i]=1.
REQ-013 The FSM SHALL have exactly four states: IDLE, REQ, GRANT and RELEASE.
REQ-014 IDLE->REQ SHALL occur on the first cycle any request is valid. The winner SHALL be chosen round-robin, searching from (last_grant+1) mod NSLOTS upward with wrap, and SHALL be latched into GRANT_ID on that edge.
REQ-015 In REQ, BUSRQ_B SHALL be driven 0 (registered) starting the cycle after entry.
REQ-016 REQ->GRANT SHALL occur when BUSACK_B is sampled 0. In GRANT, SLOT_BUSACK_B[GRANT_ID]=0 and all other bits SHALL be 1, giving a grant latency of 1 cycle from sampled BUSACK_B.
REQ-017 REQ->RELEASE SHALL occur if the latched slot's request goes invalid before BUSACK_B is seen (withdrawal). No SLOT_BUSACK_B bit SHALL be asserted in that case.
REQ-018 GRANT->RELEASE SHALL occur when the granted slot's request goes invalid, including SLOT_EN[GRANT_ID] falling mid-grant. SLOT_BUSACK_B SHALL go all-1 on the same edge.
REQ-019 In RELEASE, BUSRQ_B SHALL be 1. RELEASE->IDLE SHALL occur when BUSACK_B is sampled 1.
REQ-020 The pointer last_grant SHALL update only on REQ->GRANT. A withdrawn request SHALL NOT advance it.
REQ-021 Requests from other slots arriving during REQ, GRANT or RELEASE SHALL be held off. No preemption SHALL occur; they are served after IDLE is re-entered.
REQ-022 When several requests are valid simultaneously in IDLE, exactly one slot SHALL be granted, per the REQ-014 order.
REQ-023 The BUSRESET_B counter SHALL load RST_STRETCH while RESET_B=0 and decrement to 0 afterwards. BUSRESET_B SHALL be 0 while RESET_B=0 or the count is nonzero, and registered.
REQ-024 While BUSRESET_B=0, the FSM SHALL stay in IDLE and ignore requests.

Reset
REQ-025 On RESET_B=0 sampled at a CLK edge, the block SHALL go to: state IDLE; BUSRQ_B=1; SLOT_BUSACK_B all 1; GRANT_ID=0; last_grant=NSLOTS-1 (so slot 0 wins first); BUSY=0; BUSRESET_B=0; counter=RST_STRETCH.
REQ-026 A reset asserted mid-grant SHALL drop BUSRQ_B and SLOT_BUSACK_B to 1 on that edge, with no RELEASE handshake.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, REQ=1, GRANT=2, RELEASE=3) and the GRANT_ID width function.
REQ-028 The round-robin priority search SHALL be one sub-module, rr_pick (inputs req vector and pointer; outputs valid and index), which is combinational.
REQ-029 The reset stretcher and the arbiter FSM SHALL both reside in cpc_backplane_arbiter.

Verification
REQ-030 Reset release with RST_STRETCH=16 -> BUSRESET_B SHALL be low for exactly 16 cycles after RESET_B rises, and requests SHALL be ignored until then.
REQ-031 Slot 2 requests, CPU acks 3 cycles after BUSRQ_B -> SLOT_BUSACK_B=4'b1011 one cycle after the ack, GRANT_ID=2, then a clean release when slot 2 drops its request.
REQ-032 Slots 0,1,3 request continuously with NSLOTS=4 -> grant order SHALL be 0,1,3,0,1,3.
REQ-033 Slot 1 withdraws its request in REQ before the ack -> no SLOT_BUSACK_B bit SHALL be asserted, and the next grant SHALL still favour slot 1 if it re-requests.
REQ-034 SLOT_EN[3] is cleared during the slot-3 grant -> SLOT_BUSACK_B[3]=1 on the next edge, followed by RELEASE and then IDLE.
REQ-035 SLOT_ROMDIS=4'b0100 with SLOT_EN=4'b1011 -> ROMDIS=0; with SLOT_EN=4'b1111 -> ROMDIS=1 in the same cycle.
